cc_miss_req_issuer: RTL and testbench
=====================================

CC_MISS_REQ_ISSUER -- requirements
Module: CC_MISS_REQ_ISSUER

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- MAX_OUTSTANDING, 4, maximum issued memory bursts awaiting rlast (range 1..7).
- AR_ID, 4'd0, constant value driven on mem_arid_o.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock; all logic on rising edge.
- rst, in, 1, reset, synchronous, active-high.
- miss_req_fifo_empty_i, in, 1, miss request FIFO empty.
- miss_req_fifo_rdata_i, in, 32, head-of-FIFO miss byte address (show-ahead, valid when not empty).
- miss_req_fifo_rden_o, out, 1, pop FIFO head this cycle.
- mem_arid_o, out, 4, AR ID.
- mem_araddr_o, out, 32, AR address.
- mem_arlen_o, out, 4, AR burst length minus 1.
- mem_arsize_o, out, 3, AR beat size.
- mem_arburst_o, out, 2, AR burst type.
- mem_arvalid_o, out, 1, AR valid.
- mem_arready_i, in, 1, AR ready.
- mem_rvalid_i, in, 1, R valid (monitor only).
- mem_rready_i, in, 1, R ready as driven by the R consumer (monitor only).
- mem_rlast_i, in, 1, R last beat (monitor only).
- outstanding_cnt_o, out, 3, bursts accepted on AR with rlast not yet seen.
- busy_o, out, 1, 1 when mem_arvalid_o=1 or outstanding_cnt_o!=0.
- err_o, out, 1, sticky protocol error flag.

REQ-003 Clock and reset SHALL be: one clock; reset is synchronous and active-high.

Function
REQ-004 FSM SHALL have exactly two states: IDLE and REQ.
REQ-005 In IDLE, if miss_req_fifo_empty_i=0 and outstanding_cnt_o<MAX_OUTSTANDING, miss_req_fifo_rden_o SHALL be 1 (combinational) for that cycle only, and the FSM SHALL move to REQ.
REQ-006 On the pop cycle, the block SHALL register mem_araddr_o={miss_req_fifo_rdata_i[31:3],3'b000} (critical-word-first, 8-byte aligned).
REQ-007 mem_arvalid_o SHALL be 1 exactly while in REQ; it first asserts on the cycle after the pop (latency 1).
REQ-008 While mem_arvalid_o=1 and mem_arready_i=0, all AR outputs SHALL hold stable.
REQ-009 AR field values SHALL be constant: mem_arlen_o=4'd7 (8 beats, 64-byte line), mem_arsize_o=3'd3, mem_arburst_o=2'b10 (WRAP), mem_arid_o=AR_ID.
REQ-010 On an AR handshake (mem_arvalid_o & mem_arready_i), the FSM SHALL return to IDLE; no pop occurs in the handshake cycle. Minimum spacing is therefore 2 cycles per request.
REQ-011 outstanding_cnt_o SHALL increment by 1 on an AR handshake.
REQ-012 outstanding_cnt_o SHALL decrement by 1 on an rlast handshake (mem_rvalid_i & mem_rready_i & mem_rlast_i).
REQ-013 When an AR handshake and an rlast handshake occur in the same cycle, the count SHALL be unchanged.
REQ-014 If outstanding_cnt_o=MAX_OUTSTANDING, no pop SHALL occur. Pops resume in the cycle after a decrement.
REQ-015 If an rlast handshake arrives while the count is 0 and no AR handshake occurs that cycle, the count SHALL stay 0 and err_o SHALL set.
REQ-016 If an AR handshake would exceed MAX_OUTSTANDING, err_o SHALL set and the count SHALL saturate.
REQ-017 err_o SHALL clear only on reset.
REQ-018 A non-last R beat SHALL not change any state.

Reset
REQ-019 While rst=1 at a clock edge, the block SHALL set: FSM=IDLE, mem_arvalid_o=0, mem_araddr_o=0, outstanding_cnt_o=0, err_o=0.
REQ-020 While rst=1, miss_req_fifo_rden_o SHALL be 0.
REQ-021 If rst is asserted while in REQ, the pending request SHALL be dropped (not reissued), and mem_arvalid_o SHALL be 0 from the next cycle.
REQ-022 Constant AR fields SHALL be valid in reset.

Verification
REQ-023 Single miss: FIFO head 0x0000_1234, mem_arready_i=1 -> rden pulse cycle 0; cycle 1 arvalid=1, araddr=0x0000_1230, arlen=7, arsize=3, arburst=2; count becomes 1.
REQ-024 Backpressure: arready low for 5 cycles -> arvalid and araddr stable for 5 cycles; handshake on cycle 6; no second pop before the cycle after the handshake.
REQ-025 Limit: 6 queued misses, no rlast, MAX_OUTSTANDING=4 -> exactly 4 AR handshakes, count=4, FIFO keeps 2. One rlast handshake -> count=3, then next pop the following cycle.
REQ-026 Simultaneous: AR handshake and rlast handshake in the same cycle at count=2 -> count stays 2, err_o=0.
REQ-027 Error: rlast handshake at count=0 -> count stays 0, err_o=1 until rst.
REQ-028 Reset mid-REQ: rst=1 during arvalid -> next cycle arvalid=0, count=0, FSM=IDLE, no rden.

Source files
------------

// File: rtl/cc_miss_req_issuer_if.sv
// cc_miss_req_issuer_if: miss FIFO, AR channel, R monitor and status signals of the miss request issuer
interface cc_miss_req_issuer_if;
    logic        miss_req_fifo_empty_i;
    logic [31:0] miss_req_fifo_rdata_i;
    logic        miss_req_fifo_rden_o;
    logic [3:0]  mem_arid_o;
    logic [31:0] mem_araddr_o;
    logic [3:0]  mem_arlen_o;
    logic [2:0]  mem_arsize_o;
    logic [1:0]  mem_arburst_o;
    logic        mem_arvalid_o;
    logic        mem_arready_i;
    logic        mem_rvalid_i;
    logic        mem_rready_i;
    logic        mem_rlast_i;
    logic [2:0]  outstanding_cnt_o;
    logic        busy_o;
    logic        err_o;

    modport master (
        input  miss_req_fifo_empty_i, miss_req_fifo_rdata_i, mem_arready_i,
               mem_rvalid_i, mem_rready_i, mem_rlast_i,
        output miss_req_fifo_rden_o, mem_arid_o, mem_araddr_o, mem_arlen_o, mem_arsize_o,
               mem_arburst_o, mem_arvalid_o, outstanding_cnt_o, busy_o, err_o
    );

    modport slave (
        output miss_req_fifo_empty_i, miss_req_fifo_rdata_i, mem_arready_i,
               mem_rvalid_i, mem_rready_i, mem_rlast_i,
        input  miss_req_fifo_rden_o, mem_arid_o, mem_araddr_o, mem_arlen_o, mem_arsize_o,
               mem_arburst_o, mem_arvalid_o, outstanding_cnt_o, busy_o, err_o
    );
endinterface

// File: rtl/cc_miss_req_issuer.sv
// cc_miss_req_issuer: pops cache miss addresses and issues 64-byte WRAP line fills on AR, tracking outstanding bursts
module cc_miss_req_issuer #(
    parameter int         MAX_OUTSTANDING = 4,
    parameter logic [3:0] AR_ID           = 4'd0
) (
    input logic                  clk,
    input logic                  rst,
    cc_miss_req_issuer_if.master bus
);
    typedef enum logic {IDLE, REQ} state_t;

    localparam logic [2:0] MAX = 3'(MAX_OUTSTANDING);

    state_t      state, state_nxt;
    logic [31:0] araddr;
    logic [2:0]  cnt;
    logic        err;
    logic        pop, arvalid, ar_hs, rl_hs;

    // state register; reset drops any pending request
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nxt;

    // next state: pop moves to REQ, AR handshake returns to IDLE
    always_comb
        state_nxt = (state == IDLE) ? (pop ? REQ : IDLE) : (ar_hs ? IDLE : REQ);

    // outputs decoded from state and handshakes
    always_comb begin
        arvalid = state == REQ;
        pop     = (state == IDLE) && !bus.miss_req_fifo_empty_i && (cnt < MAX) && !rst;
        ar_hs   = arvalid && bus.mem_arready_i;
        rl_hs   = bus.mem_rvalid_i && bus.mem_rready_i && bus.mem_rlast_i;
    end

    // capture the line address (8-byte aligned, critical word first) on the pop
    always_ff @(posedge clk)
        if (rst) araddr <= '0;
        else if (pop) araddr <= {bus.miss_req_fifo_rdata_i[31:3], 3'b000};

    // outstanding burst count with sticky error on underflow/overflow
    always_ff @(posedge clk)
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else if (ar_hs && !rl_hs) begin
            if (cnt >= MAX) err <= 1'b1;
            else cnt <= cnt + 3'd1;
        end else if (rl_hs && !ar_hs) begin
            if (cnt == '0) err <= 1'b1;
            else cnt <= cnt - 3'd1;
        end

    assign bus.miss_req_fifo_rden_o = pop;
    assign bus.mem_arid_o           = AR_ID;
    assign bus.mem_araddr_o         = araddr;
    assign bus.mem_arlen_o          = 4'd7;
    assign bus.mem_arsize_o         = 3'd3;
    assign bus.mem_arburst_o        = 2'b10;
    assign bus.mem_arvalid_o        = arvalid;
    assign bus.outstanding_cnt_o    = cnt;
    assign bus.busy_o               = arvalid || (cnt != '0);
    assign bus.err_o                = err;
endmodule

// File: tb/tb_cc_miss_req_issuer.sv
// tb_cc_miss_req_issuer: directed scenario tests for the miss request issuer
module tb_cc_miss_req_issuer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    cc_miss_req_issuer_if bus ();

    cc_miss_req_issuer #(.MAX_OUTSTANDING(4), .AR_ID(4'd0)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // show-ahead FIFO model
    logic [31:0] mem [8];
    logic [3:0]  wp = '0;
    logic [3:0]  rp = '0;
    int          ar_hs_n = 0;

    assign bus.miss_req_fifo_empty_i = (wp == rp);
    assign bus.miss_req_fifo_rdata_i = mem[rp[2:0]];

    // FIFO pop and AR handshake counter
    always @(posedge clk) begin
        if (bus.miss_req_fifo_rden_o) rp <= rp + 4'd1;
        if (bus.mem_arvalid_o && bus.mem_arready_i) ar_hs_n <= ar_hs_n + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a);
        mem[wp[2:0]] = a;
        wp = wp + 4'd1;
    endtask

    task automatic rlast_beats(input int k);
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rready_i = 1'b1;
        bus.mem_rlast_i  = 1'b1;
        repeat (k) tick();
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rready_i = 1'b0;
        bus.mem_rlast_i  = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_chk++; if (bus.mem_arvalid_o !== 1'b0) begin n_fail++; $display("FAIL rst_arvalid: got %b exp 0", bus.mem_arvalid_o); end
        n_chk++; if (bus.mem_araddr_o !== 32'h0) begin n_fail++; $display("FAIL rst_araddr: got %h exp 0", bus.mem_araddr_o); end
        n_chk++; if (bus.outstanding_cnt_o !== 3'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d exp 0", bus.outstanding_cnt_o); end
        n_chk++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b exp 0", bus.err_o); end
        n_chk++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", bus.busy_o); end
        n_chk++; if (bus.mem_arlen_o !== 4'd7) begin n_fail++; $display("FAIL rst_arlen: got %0d exp 7", bus.mem_arlen_o); end
        n_chk++; if (bus.mem_arsize_o !== 3'd3) begin n_fail++; $display("FAIL rst_arsize: got %0d exp 3", bus.mem_arsize_o); end
        n_chk++; if (bus.mem_arburst_o !== 2'b10) begin n_fail++; $display("FAIL rst_arburst: got %b exp 10", bus.mem_arburst_o); end
        n_chk++; if (bus.mem_arid_o !== 4'd0) begin n_fail++; $display("FAIL rst_arid: got %h exp 0", bus.mem_arid_o); end
        push(32'h0000_1234);
        #1;
        n_chk++; if (bus.miss_req_fifo_rden_o !== 1'b0) begin n_fail++; $display("FAIL rst_rden: got %b exp 0", bus.miss_req_fifo_rden_o); end
        tick();
        n_chk++; if (bus.mem_arvalid_o !== 1'b0) begin n_fail++; $display("FAIL rst_no_req: got %b exp 0", bus.mem_arvalid_o); end
    endtask

    task automatic test_single_miss();
        rst = 1'b0;
        #1;
        n_chk++; if (bus.miss_req_fifo_rden_o !== 1'b1) begin n_fail++; $display("FAIL single_rden: got %b exp 1", bus.miss_req_fifo_rden_o); end
        n_chk++; if (bus.mem_arvalid_o !== 1'b0) begin n_fail++; $display("FAIL single_arvalid_c0: got %b exp 0", bus.mem_arvalid_o); end
        tick();
        n_chk++; if (bus.mem_arvalid_o !== 1'b1) begin n_fail++; $display("FAIL single_arvalid_c1: got %b exp 1", bus.mem_arvalid_o); end
        n_chk++; if (bus.mem_araddr_o !== 32'h0000_1230) begin n_fail++; $display("FAIL single_araddr: got %h exp 00001230", bus.mem_araddr_o); end
        n_chk++; if (bus.miss_req_fifo_rden_o !== 1'b0) begin n_fail++; $display("FAIL single_rden_c1: got %b exp 0", bus.miss_req_fifo_rden_o); end
        n_chk++; if ({bus.mem_arlen_o, bus.mem_arsize_o, bus.mem_arburst_o} !== {4'd7, 3'd3, 2'b10}) begin n_fail++; $display("FAIL single_fields: got %h/%h/%h exp 7/3/2", bus.mem_arlen_o, bus.mem_arsize_o, bus.mem_arburst_o); end
        n_chk++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b exp 1", bus.busy_o); end
        tick();
        n_chk++; if (bus.mem_arvalid_o !== 1'b0) begin n_fail++; $display("FAIL single_arvalid_c2: got %b exp 0", bus.mem_arvalid_o); end
        n_chk++; if (bus.outstanding_cnt_o !== 3'd1) begin n_fail++; $display("FAIL single_cnt: got %0d exp 1", bus.outstanding_cnt_o); end
        rlast_beats(1);
        n_chk++; if (bus.outstanding_cnt_o !== 3'd0) begin n_fail++; $display("FAIL single_drain: got %0d exp 0", bus.outstanding_cnt_o); end
        n_chk++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy: got %b exp 0", bus.busy_o); end
    endtask

    task automatic test_backpressure();
        bus.mem_arready_i = 1'b0;
        push(32'h8000_00FF);
        push(32'h0000_0040);
        #1;
        n_chk++; if (bus.miss_req_fifo_rden_o !== 1'b1) begin n_fail++; $display("FAIL bp_rden0: got %b exp 1", bus.miss_req_fifo_rden_o); end
        tick();
        for (int i = 1; i <= 5; i++) begin
            n_chk++; if ({bus.mem_arvalid_o, bus.mem_araddr_o, bus.miss_req_fifo_rden_o} !== {1'b1, 32'h8000_00F8, 1'b0}) begin n_fail++; $display("FAIL bp_hold_c%0d: got v=%b a=%h r=%b exp v=1 a=800000f8 r=0", i, bus.mem_arvalid_o, bus.mem_araddr_o, bus.miss_req_fifo_rden_o); end
            tick();
        end
        bus.mem_arready_i = 1'b1;
        #1;
        n_chk++; if ({bus.mem_arvalid_o, bus.miss_req_fifo_rden_o} !== 2'b10) begin n_fail++; $display("FAIL bp_hs_cycle: got v=%b r=%b exp v=1 r=0", bus.mem_arvalid_o, bus.miss_req_fifo_rden_o); end
        tick();
        n_chk++; if ({bus.mem_arvalid_o, bus.miss_req_fifo_rden_o} !== 2'b01) begin n_fail++; $display("FAIL bp_next_pop: got v=%b r=%b exp v=0 r=1", bus.mem_arvalid_o, bus.miss_req_fifo_rden_o); end
        n_chk++; if (bus.outstanding_cnt_o !== 3'd1) begin n_fail++; $display("FAIL bp_cnt1: got %0d exp 1", bus.outstanding_cnt_o); end
        tick();
        n_chk++; if (bus.mem_araddr_o !== 32'h0000_0040) begin n_fail++; $display("FAIL bp_araddr2: got %h exp 00000040", bus.mem_araddr_o); end
        tick();
        n_chk++; if (bus.outstanding_cnt_o !== 3'd2) begin n_fail++; $display("FAIL bp_cnt2: got %0d exp 2", bus.outstanding_cnt_o); end
        rlast_beats(2);
        n_chk++; if (bus.outstanding_cnt_o !== 3'd0) begin n_fail++; $display("FAIL bp_drain: got %0d exp 0", bus.outstanding_cnt_o); end
    endtask

    task automatic test_simultaneous();
        push(32'h0000_1000);
        push(32'h0000_2000);
        push(32'h0000_3000);
        #1;
        repeat (4) tick();
        n_chk++; if (bus.outstanding_cnt_o !== 3'd2) begin n_fail++; $display("FAIL sim_cnt_pre: got %0d exp 2", bus.outstanding_cnt_o); end
        tick();
        n_chk++; if (bus.mem_arvalid_o !== 1'b1) begin n_fail++; $display("FAIL sim_arvalid: got %b exp 1", bus.mem_arvalid_o); end
        rlast_beats(1);
        n_chk++; if (bus.outstanding_cnt_o !== 3'd2) begin n_fail++; $display("FAIL sim_cnt: got %0d exp 2", bus.outstanding_cnt_o); end
        n_chk++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL sim_err: got %b exp 0", bus.err_o); end
        n_chk++; if (bus.mem_arvalid_o !== 1'b0) begin n_fail++; $display("FAIL sim_idle: got %b exp 0", bus.mem_arvalid_o); end
        rlast_beats(2);
        n_chk++; if (bus.outstanding_cnt_o !== 3'd0) begin n_fail++; $display("FAIL sim_drain: got %0d exp 0", bus.outstanding_cnt_o); end
    endtask

    task automatic test_limit();
        int hs0;
        hs0 = ar_hs_n;
        for (int i = 0; i < 6; i++) push(32'h0001_0000 + 32'(i * 64));
        #1;
        repeat (14) tick();
        n_chk++; if (ar_hs_n - hs0 !== 4) begin n_fail++; $display("FAIL lim_hs: got %0d exp 4", ar_hs_n - hs0); end
        n_chk++; if (bus.outstanding_cnt_o !== 3'd4) begin n_fail++; $display("FAIL lim_cnt: got %0d exp 4", bus.outstanding_cnt_o); end
        n_chk++; if (4'(wp - rp) !== 4'd2) begin n_fail++; $display("FAIL lim_fifo: got %0d exp 2", 4'(wp - rp)); end
        n_chk++; if ({bus.miss_req_fifo_rden_o, bus.mem_arvalid_o} !== 2'b00) begin n_fail++; $display("FAIL lim_stall: got r=%b v=%b exp 00", bus.miss_req_fifo_rden_o, bus.mem_arvalid_o); end
        rlast_beats(1);
        n_chk++; if (bus.outstanding_cnt_o !== 3'd3) begin n_fail++; $display("FAIL lim_dec: got %0d exp 3", bus.outstanding_cnt_o); end
        n_chk++; if (bus.miss_req_fifo_rden_o !== 1'b1) begin n_fail++; $display("FAIL lim_resume: got %b exp 1", bus.miss_req_fifo_rden_o); end
        tick();
        n_chk++; if (bus.mem_araddr_o !== 32'h0001_0100) begin n_fail++; $display("FAIL lim_araddr5: got %h exp 00010100", bus.mem_araddr_o); end
        tick();
        n_chk++; if (bus.outstanding_cnt_o !== 3'd4) begin n_fail++; $display("FAIL lim_cnt4b: got %0d exp 4", bus.outstanding_cnt_o); end
        rlast_beats(1);
        repeat (2) tick();
        rlast_beats(4);
        n_chk++; if ({bus.outstanding_cnt_o, bus.err_o} !== {3'd0, 1'b0}) begin n_fail++; $display("FAIL lim_drain: got cnt=%0d err=%b exp 0/0", bus.outstanding_cnt_o, bus.err_o); end
        n_chk++; if (wp !== rp) begin n_fail++; $display("FAIL lim_fifo_empty: got %0d entries exp 0", 4'(wp - rp)); end
    endtask

    task automatic test_error();
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rready_i = 1'b1;
        tick();
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rready_i = 1'b0;
        #1;
        n_chk++; if ({bus.outstanding_cnt_o, bus.err_o} !== {3'd0, 1'b0}) begin n_fail++; $display("FAIL err_nonlast: got cnt=%0d err=%b exp 0/0", bus.outstanding_cnt_o, bus.err_o); end
        rlast_beats(1);
        n_chk++; if (bus.outstanding_cnt_o !== 3'd0) begin n_fail++; $display("FAIL err_cnt: got %0d exp 0", bus.outstanding_cnt_o); end
        n_chk++; if (bus.err_o !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b exp 1", bus.err_o); end
        repeat (3) tick();
        n_chk++; if (bus.err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b exp 1", bus.err_o); end
    endtask

    task automatic test_reset_mid_req();
        int hs0;
        bus.mem_arready_i = 1'b0;
        push(32'h0000_2004);
        #1;
        tick();
        n_chk++; if (bus.mem_arvalid_o !== 1'b1) begin n_fail++; $display("FAIL mid_arvalid: got %b exp 1", bus.mem_arvalid_o); end
        hs0 = ar_hs_n;
        rst = 1'b1;
        push(32'h0000_5000);
        #1;
        n_chk++; if (bus.miss_req_fifo_rden_o !== 1'b0) begin n_fail++; $display("FAIL mid_rden_rst: got %b exp 0", bus.miss_req_fifo_rden_o); end
        tick();
        n_chk++; if ({bus.mem_arvalid_o, bus.outstanding_cnt_o, bus.err_o} !== {1'b0, 3'd0, 1'b0}) begin n_fail++; $display("FAIL mid_reset: got v=%b cnt=%0d err=%b exp 0/0/0", bus.mem_arvalid_o, bus.outstanding_cnt_o, bus.err_o); end
        n_chk++; if (bus.miss_req_fifo_rden_o !== 1'b0) begin n_fail++; $display("FAIL mid_rden: got %b exp 0", bus.miss_req_fifo_rden_o); end
        rst = 1'b0;
        bus.mem_arready_i = 1'b1;
        #1;
        n_chk++; if (bus.miss_req_fifo_rden_o !== 1'b1) begin n_fail++; $display("FAIL mid_rden_after: got %b exp 1", bus.miss_req_fifo_rden_o); end
        tick();
        n_chk++; if (bus.mem_araddr_o !== 32'h0000_5000) begin n_fail++; $display("FAIL mid_next_addr: got %h exp 00005000 (dropped request reissued)", bus.mem_araddr_o); end
        tick();
        n_chk++; if (ar_hs_n - hs0 !== 1) begin n_fail++; $display("FAIL mid_hs: got %0d exp 1", ar_hs_n - hs0); end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.mem_arready_i = 1'b1;
        bus.mem_rvalid_i  = 1'b0;
        bus.mem_rready_i  = 1'b0;
        bus.mem_rlast_i   = 1'b0;
        test_reset();
        test_single_miss();
        test_backpressure();
        test_simultaneous();
        test_limit();
        test_error();
        test_reset_mid_req();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
